// File: rtl/pipe_stage_pkg.sv
// Shared types for the elastic pipeline stage register.
package pipe_stage_pkg;

  // Occupancy-encoded stage state; 2'd3 is illegal and recovers to StEmpty.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StFull  = 2'd1,
    StSkid  = 2'd2
  } state_e;

  localparam int unsigned PERF_CNT_W = 32;

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register: valid/ready handshake with a 2-entry skid buffer
// so in_ready is a pure decode of registered state.
// Optional build macro PIPE_STAGE_PERF_EN adds stall_cycles and occupancy outputs.
module pipe_stage_reg
  import pipe_stage_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cycles,
  output logic [1:0]            occupancy
`endif
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire, out_fire;

  assign out_valid = (state_q != StEmpty);
  assign in_ready  = (state_q != StSkid);
  assign out_data  = main_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Next-state and datapath selection; flush discards any same-cycle in_fire.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StFull;
            main_d  = in_data;
          end
        end
        StFull: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            state_d = StSkid;
            skid_d  = in_data;
          end else if (out_fire) begin
            state_d = StEmpty;
            main_d  = BUBBLE;
          end
        end
        StSkid: begin
          // in_ready is low here, so only the drain path exists.
          if (out_fire) begin
            state_d = StFull;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
  end

  // State and payload registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [PERF_CNT_W-1:0] stall_q, stall_d;

  // Saturating count of cycles the head entry waits on downstream.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {PERF_CNT_W{1'b1}})) begin
      stall_d = stall_q + {{(PERF_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Stall counter register; only reset clears it, flush leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;

  // Held-entry count decoded from state.
  always_comb begin
    case (state_q)
      StFull:  occupancy = 2'd1;
      StSkid:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end
`endif

endmodule
